// File: rtl/req_ack_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : req_ack_pkg
// Description : Shared types and defaults for the req/ack arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package req_ack_pkg;

    localparam int DEFAULT_N_REQ   = 4;
    localparam int DEFAULT_TIMEOUT = 15;
    localparam int CNT_W           = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/req_ack_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : req_ack_arbiter_if
// Description : Requester and shared-target handshake bundle of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface req_ack_arbiter_if #(
    parameter int N_REQ = req_ack_pkg::DEFAULT_N_REQ
);
    logic [N_REQ-1:0] req_i;
    logic [N_REQ-1:0] ack_o;
    logic [N_REQ-1:0] grant_o;
    logic             tgt_req;
    logic             tgt_ack;
    logic             busy;
    logic             timeout_err;

    // Arbiter side
    modport master (
        input  req_i,
        input  tgt_ack,
        output ack_o,
        output grant_o,
        output tgt_req,
        output busy,
        output timeout_err
    );

    // Requesters and target side
    modport slave (
        output req_i,
        output tgt_ack,
        input  ack_o,
        input  grant_o,
        input  tgt_req,
        input  busy,
        input  timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/req_ack_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first set request at or
//               above the pointer, wrapping to the lowest set request below it.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import req_ack_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [N_REQ-1:0] o_grant,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_valid
);

    localparam logic [N_REQ-1:0] c_one = N_REQ'(1);

    logic             w_hi_found;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_lo_idx;

    // Scanning downward leaves the lowest qualifying index in each half.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                if (IDX_W'(i) >= i_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IDX_W'(i);
                end else begin
                    w_lo_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign o_valid = |i_req;
    assign o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
    assign o_grant = o_valid ? (c_one << o_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/req_ack_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : req_ack_arbiter
// Description : Round-robin arbiter granting N_REQ requesters access to one
//               req/ack target, with wait timeout and a one-cycle release gap.
// Revision    : 1.0 - initial release
// ============================================================================
module req_ack_arbiter
    import req_ack_pkg::*;
#(
    parameter int N_REQ   = DEFAULT_N_REQ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  wire logic       clk,
    input  wire logic       rst,
    req_ack_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_winner;
    logic [IDX_W-1:0] w_winner_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_ptr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] w_grant_nxt;
    logic [N_REQ-1:0] r_ack;
    logic [N_REQ-1:0] w_ack_nxt;
    logic             r_tgt_req;
    logic             w_tgt_req_nxt;
    logic             r_busy;
    logic             r_timeout_err;
    logic             w_timeout_err_nxt;

    logic [N_REQ-1:0] w_pick_grant;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic [IDX_W-1:0] w_ptr_after;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .i_req   (bus.req_i),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_ptr_after = (r_winner == IDX_W'(N_REQ - 1)) ? '0 : r_winner + IDX_W'(1);

    always_comb begin
        w_state_nxt       = r_state;
        w_winner_nxt      = r_winner;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_cnt_nxt         = r_cnt;
        w_grant_nxt       = r_grant;
        w_tgt_req_nxt     = r_tgt_req;
        w_ack_nxt         = '0;
        w_timeout_err_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt   = WAIT;
                    w_winner_nxt  = w_pick_idx;
                    w_grant_nxt   = w_pick_grant;
                    w_tgt_req_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                end
            end
            WAIT: begin
                // Ack wins a same-cycle race with the timeout.
                if (bus.tgt_ack) begin
                    w_state_nxt   = RELEASE;
                    w_ack_nxt     = r_grant;
                    w_grant_nxt   = '0;
                    w_tgt_req_nxt = 1'b0;
                    w_rr_ptr_nxt  = w_ptr_after;
                    w_cnt_nxt     = '0;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt       = RELEASE;
                    w_timeout_err_nxt = 1'b1;
                    w_grant_nxt       = '0;
                    w_tgt_req_nxt     = 1'b0;
                    w_rr_ptr_nxt      = w_ptr_after;
                    w_cnt_nxt         = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt   = IDLE;
                w_grant_nxt   = '0;
                w_tgt_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_winner      <= '0;
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_ack         <= '0;
            r_tgt_req     <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_winner      <= w_winner_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_grant       <= w_grant_nxt;
            r_ack         <= w_ack_nxt;
            r_tgt_req     <= w_tgt_req_nxt;
            r_busy        <= (w_state_nxt != IDLE);
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign bus.grant_o     = r_grant;
    assign bus.ack_o       = r_ack;
    assign bus.tgt_req     = r_tgt_req;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_req_ack_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_req_ack_arbiter
// Description : Self-checking bench for req_ack_arbiter (N_REQ=4, TIMEOUT=15).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_req_ack_arbiter;

    typedef struct {
        logic [3:0] req;
        logic [3:0] hold;
        int         delay;
        bit         spur;
        logic [3:0] grant;
        logic [3:0] ack;
        bit         to;
    } vec_t;

    typedef struct {
        logic [3:0] grant;
        logic [3:0] ack;
        bit         to;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];
    vec_t vecs[16];

    req_ack_arbiter_if #(.N_REQ(4)) bus ();

    req_ack_arbiter #(
        .N_REQ   (4),
        .TIMEOUT (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   n;
        bit   seen;
        bus.req_i = v.req;
        sb.push_back('{grant: v.grant, ack: v.ack, to: v.to});
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 4) begin
            tick();
            n++;
            if (bus.tgt_req) seen = 1'b1;
        end
        e = sb.pop_front();
        if (!seen) begin
            chk($sformatf("v%0d_no_grant", idx), 32'(bus.tgt_req), 32'd1);
            bus.req_i = '0;
            return;
        end
        chk($sformatf("v%0d_grant_lat", idx), 32'(n), 32'd1);
        chk($sformatf("v%0d_grant", idx), 32'(bus.grant_o), 32'(e.grant));
        chk($sformatf("v%0d_busy", idx), 32'(bus.busy), 32'd1);
        bus.req_i = v.hold;
        if (v.delay >= 0) begin
            repeat (v.delay) begin
                tick();
                chk($sformatf("v%0d_grant_hold", idx), 32'(bus.grant_o), 32'(e.grant));
            end
            bus.tgt_ack = 1'b1;
            tick();
            bus.tgt_ack = 1'b0;
        end else begin
            tick();
            n = 1;
            while (!bus.timeout_err && bus.ack_o == 4'b0 && n < 40) begin
                tick();
                n++;
            end
            chk($sformatf("v%0d_to_latency", idx), 32'(n), 32'd15);
        end
        chk($sformatf("v%0d_ack", idx), 32'(bus.ack_o), 32'(e.ack));
        chk($sformatf("v%0d_timeout_err", idx), 32'(bus.timeout_err), 32'(e.to));
        chk($sformatf("v%0d_rel_tgt_req", idx), 32'(bus.tgt_req), 32'd0);
        chk($sformatf("v%0d_rel_grant", idx), 32'(bus.grant_o), 32'd0);
        chk($sformatf("v%0d_rel_busy", idx), 32'(bus.busy), 32'd1);
        if (v.spur) bus.tgt_ack = 1'b1;
        tick();
        bus.tgt_ack = 1'b0;
        chk($sformatf("v%0d_idle_busy", idx), 32'(bus.busy), 32'd0);
        chk($sformatf("v%0d_idle_ack", idx), 32'(bus.ack_o), 32'd0);
        chk($sformatf("v%0d_idle_to", idx), 32'(bus.timeout_err), 32'd0);
        chk($sformatf("v%0d_idle_tgt_req", idx), 32'(bus.tgt_req), 32'd0);
        bus.req_i = '0;
    endtask

    initial begin
        logic [3:0] g;
        n_chk  = 0;
        n_fail = 0;

        // Fairness: all four requesting, expected rotation 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++) begin
            g = 4'b0001 << (i % 4);
            vecs[i] = '{req: 4'b1111, hold: 4'b1111, delay: 2, spur: 1'b0,
                        grant: g, ack: g, to: 1'b0};
        end
        vecs[8]  = '{req: 4'b0001, hold: 4'b0001, delay: 2,  spur: 1'b0, grant: 4'b0001, ack: 4'b0001, to: 1'b0};
        vecs[9]  = '{req: 4'b0100, hold: 4'b0100, delay: -1, spur: 1'b0, grant: 4'b0100, ack: 4'b0000, to: 1'b1};
        vecs[10] = '{req: 4'b0101, hold: 4'b0101, delay: 0,  spur: 1'b0, grant: 4'b0001, ack: 4'b0001, to: 1'b0};
        vecs[11] = '{req: 4'b1010, hold: 4'b0000, delay: 3,  spur: 1'b0, grant: 4'b0010, ack: 4'b0010, to: 1'b0};
        vecs[12] = '{req: 4'b1000, hold: 4'b1000, delay: 14, spur: 1'b0, grant: 4'b1000, ack: 4'b1000, to: 1'b0};
        vecs[13] = '{req: 4'b0110, hold: 4'b0110, delay: 1,  spur: 1'b1, grant: 4'b0010, ack: 4'b0010, to: 1'b0};
        vecs[14] = '{req: 4'b1001, hold: 4'b1001, delay: 13, spur: 1'b0, grant: 4'b1000, ack: 4'b1000, to: 1'b0};
        vecs[15] = '{req: 4'b1001, hold: 4'b1001, delay: 2,  spur: 1'b0, grant: 4'b0001, ack: 4'b0001, to: 1'b0};

        rst         = 1'b1;
        bus.req_i   = '0;
        bus.tgt_ack = 1'b0;
        tick();
        tick();
        chk("rst_grant", 32'(bus.grant_o), 32'd0);
        chk("rst_ack", 32'(bus.ack_o), 32'd0);
        chk("rst_tgt_req", 32'(bus.tgt_req), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        rst = 1'b0;

        // Spurious target ack while idle
        bus.tgt_ack = 1'b1;
        tick();
        bus.tgt_ack = 1'b0;
        chk("spur_idle_ack", 32'(bus.ack_o), 32'd0);
        chk("spur_idle_busy", 32'(bus.busy), 32'd0);
        chk("spur_idle_tgt_req", 32'(bus.tgt_req), 32'd0);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Reset on WAIT cycle 3, with a coincident target ack
        bus.req_i = 4'b1001;
        tick();
        chk("mid_grant", 32'(bus.grant_o), 32'b1000);
        chk("mid_tgt_req", 32'(bus.tgt_req), 32'd1);
        repeat (3) tick();
        rst         = 1'b1;
        bus.tgt_ack = 1'b1;
        tick();
        rst         = 1'b0;
        bus.tgt_ack = 1'b0;
        chk("mid_rst_grant", 32'(bus.grant_o), 32'd0);
        chk("mid_rst_ack", 32'(bus.ack_o), 32'd0);
        chk("mid_rst_tgt_req", 32'(bus.tgt_req), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        tick();
        chk("post_rst_grant", 32'(bus.grant_o), 32'b0001);
        chk("post_rst_tgt_req", 32'(bus.tgt_req), 32'd1);
        bus.tgt_ack = 1'b1;
        tick();
        bus.tgt_ack = 1'b0;
        bus.req_i   = '0;
        chk("post_rst_ack", 32'(bus.ack_o), 32'b0001);
        tick();
        chk("post_rst_idle_busy", 32'(bus.busy), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/req_ack_arbiter.md
REQ_ACK_ARBITER -- requirements
Module: req_ack_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, giving the number of requesters (legal 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 15, giving the maximum cycles in WAIT before abort (legal 4..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_i, input, N_REQ bits: level request per requester.
REQ-006 SHALL have port ack_o, output, N_REQ bits: one-cycle completion pulse to the granted requester.
REQ-007 SHALL have port grant_o, output, N_REQ bits: one-hot owner of the shared target, all-zero when none.
REQ-008 SHALL have port tgt_req, output, 1 bit: request to the shared req/ack target.
REQ-009 SHALL have port tgt_ack, input, 1 bit: one-cycle acknowledge pulse from the target.
REQ-010 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 SHALL have port timeout_err, output, 1 bit: one-cycle pulse on abort.

Function
REQ-012 SHALL implement the FSM states IDLE, WAIT, RELEASE.
REQ-013 IDLE: with any req_i bit set at edge k, SHALL latch the round-robin winner and enter WAIT, with grant_o and tgt_req high from cycle k+1.
REQ-014 Winner selection SHALL be the first set req_i bit at or above rr_ptr, wrapping from N_REQ-1 to 0.
REQ-015 WAIT: tgt_req and grant_o SHALL be held steady; the wait counter increments each cycle from 0.
REQ-016 WAIT with tgt_ack=1: SHALL pulse ack_o[winner] in the next cycle, deassert tgt_req and grant_o, and enter RELEASE.
REQ-017 WAIT with counter = TIMEOUT-1 and tgt_ack=0: SHALL pulse timeout_err and enter RELEASE; no ack_o pulse is issued.
REQ-018 tgt_ack and timeout in the same cycle SHALL be treated as ack, with no timeout_err.
REQ-019 RELEASE SHALL last exactly one cycle with tgt_req=0, so the target cannot re-capture a stale request, then enter IDLE.
REQ-020 On leaving WAIT, rr_ptr SHALL become (winner+1) mod N_REQ, both on ack and on timeout.
REQ-021 tgt_ack while not in WAIT SHALL be ignored, with no ack_o pulse.
REQ-022 A winner dropping req_i during WAIT SHALL NOT abort the transaction; it still receives ack_o.
REQ-023 At most one ack_o bit SHALL be high per cycle; grant_o SHALL be one-hot or zero.
REQ-024 Minimum back-to-back transaction spacing SHALL be: grant, target latency, RELEASE, IDLE. For a target acking 2 cycles after tgt_req, this is 5 cycles per transaction.

Reset
REQ-025 With rst high at an edge, next state SHALL be IDLE, rr_ptr=0, and the counter 0.
REQ-026 Under reset, tgt_req, grant_o, ack_o, busy and timeout_err SHALL all be 0.
REQ-027 Reset during WAIT SHALL abort silently: no ack_o pulse and no timeout_err.

Structure
REQ-028 Package req_ack_pkg SHALL hold the arb_state_t enum (IDLE, WAIT, RELEASE) and the default N_REQ and TIMEOUT constants.
REQ-029 Winner selection SHALL be a combinational sub-module rr_pick (inputs req vector and pointer; outputs one-hot grant and index).
REQ-030 All outputs SHALL be driven from registers.

Verification
REQ-031 Single requester: req_i=0001, target acks 2 cycles after tgt_req -> grant_o=0001, then ack_o[0] pulse, one RELEASE cycle, busy low after 5 cycles.
REQ-032 Fairness: req_i=1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3, with exactly one ack_o pulse each.
REQ-033 Timeout: target never acks -> timeout_err pulses 15 cycles after tgt_req rises, no ack_o, and rr_ptr advances.
REQ-034 Ack/timeout race: tgt_ack arrives on WAIT cycle 14 -> ack_o pulse and timeout_err stays 0.
REQ-035 Reset mid-WAIT: rst asserted on WAIT cycle 3 -> all outputs 0 next cycle, and the next grant goes to the lowest set requester.
REQ-036 Spurious tgt_ack in IDLE or RELEASE -> no ack_o, state unchanged.
